// File: rtl/axi4_lite_master_if.sv
// AXI4-Lite bus bundle between the axi4_lite_master initiator and a register-port slave.
interface axi4_lite_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   M_AXI_AWADDR;
  logic [2:0]          M_AXI_AWPROT;
  logic                M_AXI_AWVALID;
  logic                M_AXI_AWREADY;
  logic [DATA_W-1:0]   M_AXI_WDATA;
  logic [DATA_W/8-1:0] M_AXI_WSTRB;
  logic                M_AXI_WVALID;
  logic                M_AXI_WREADY;
  logic [1:0]          M_AXI_BRESP;
  logic                M_AXI_BVALID;
  logic                M_AXI_BREADY;
  logic [ADDR_W-1:0]   M_AXI_ARADDR;
  logic [2:0]          M_AXI_ARPROT;
  logic                M_AXI_ARVALID;
  logic                M_AXI_ARREADY;
  logic [DATA_W-1:0]   M_AXI_RDATA;
  logic [1:0]          M_AXI_RRESP;
  logic                M_AXI_RVALID;
  logic                M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, input M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, input M_AXI_WREADY,
    input M_AXI_BRESP, M_AXI_BVALID, output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, input M_AXI_ARREADY,
    input M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, output M_AXI_RREADY
  );

  modport slave (
    input M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, output M_AXI_AWREADY,
    input M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID, input M_AXI_BREADY,
    input M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, input M_AXI_RREADY
  );
endinterface

// File: rtl/axi4_lite_master.sv
// Single-outstanding command/response to AXI4-Lite initiator.
// Optional response-wait timeout enabled by defining AXI_MASTER_TIMEOUT_EN.
module axi4_lite_master #(
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_TIMEOUT_CYCLES   = 1024
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESET,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  axi4_lite_master_if.master              m_axi
);

  if (C_M_AXI_DATA_WIDTH != 32 || C_TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("axi4_lite_master: data width must be 32 and timeout at least 2");
  end

  typedef enum logic [2:0] {
    IDLE, WADDR, WRESP, RADDR, RDATA, RSP
  } state_t;

  state_t state, state_nxt;

  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]                      resp_q;
  logic awvalid_q, wvalid_q, arvalid_q;
  logic aw_done, w_done;
  logic aw_hs, w_hs, timeout;

  assign aw_hs = awvalid_q & m_axi.M_AXI_AWREADY;
  assign w_hs  = wvalid_q  & m_axi.M_AXI_WREADY;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(C_TIMEOUT_CYCLES);
  logic [CNT_W-1:0] tmo_cnt;

  // Counter restarts on every entry to a response-wait state.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) tmo_cnt <= '0;
    else if (state == WRESP || state == RDATA) tmo_cnt <= tmo_cnt + 1'b1;
    else tmo_cnt <= '0;
  end

  assign timeout = (tmo_cnt == CNT_W'(C_TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) state <= IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (cmd_valid) state_nxt = cmd_write ? WADDR : RADDR;
      WADDR: if ((aw_done | aw_hs) & (w_done | w_hs)) state_nxt = WRESP;
      WRESP: if (m_axi.M_AXI_BVALID || timeout) state_nxt = RSP;
      RADDR: if (m_axi.M_AXI_ARREADY) state_nxt = RDATA;
      RDATA: if (m_axi.M_AXI_RVALID || timeout) state_nxt = RSP;
      RSP:   if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (cmd_valid) begin
          addr_q  <= cmd_addr;
          wdata_q <= cmd_wdata;
          wstrb_q <= cmd_wstrb;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          if (cmd_write) begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
          end else begin
            arvalid_q <= 1'b1;
          end
        end
        WADDR: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done   <= 1'b1;
          end
        end
        WRESP: begin
          // A response arriving on the timeout cycle still wins.
          if (m_axi.M_AXI_BVALID) begin
            resp_q  <= m_axi.M_AXI_BRESP;
            rdata_q <= '0;
          end else if (timeout) begin
            resp_q  <= 2'b11;
            rdata_q <= '0;
          end
        end
        RADDR: if (m_axi.M_AXI_ARREADY) arvalid_q <= 1'b0;
        RDATA: begin
          if (m_axi.M_AXI_RVALID) begin
            resp_q  <= m_axi.M_AXI_RRESP;
            rdata_q <= m_axi.M_AXI_RDATA;
          end else if (timeout) begin
            resp_q  <= 2'b11;
            rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RSP);
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;

  assign m_axi.M_AXI_AWADDR  = addr_q;
  assign m_axi.M_AXI_AWPROT  = 3'b000;
  assign m_axi.M_AXI_AWVALID = awvalid_q;
  assign m_axi.M_AXI_WDATA   = wdata_q;
  assign m_axi.M_AXI_WSTRB   = wstrb_q;
  assign m_axi.M_AXI_WVALID  = wvalid_q;
  assign m_axi.M_AXI_BREADY  = (state == WRESP);
  assign m_axi.M_AXI_ARADDR  = addr_q;
  assign m_axi.M_AXI_ARPROT  = 3'b000;
  assign m_axi.M_AXI_ARVALID = arvalid_q;
  assign m_axi.M_AXI_RREADY  = (state == RDATA);

endmodule
